divuint: RTL and testbench
==========================

# divuint

Unsigned integer divider, the inverse companion of the team's sequential unsigned multiplier. It uses the same enable/busy/done/valid handshake. It computes a quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and feeds timebase scaling and unit conversion.

## Interface
- `WIDTH`, default 10: operand, quotient and remainder width in bits; legal range is 2 or more.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset; one clock; the reset polarity and synchronicity are fixed.
- `enable`  in  1: start request, sampled on `clk`; has priority over an operation in flight.
- `a`  in  WIDTH: dividend, captured on the start edge.
- `b`  in  WIDTH: divisor, captured on the start edge.
- `busy`  out  1: an operation is in progress.
- `done`  out  1: operation complete; high for exactly one cycle.
- `valid`  out  1: `quotient`, `remainder` and `div_by_zero` hold the result of the last completed operation.
- `quotient`  out  WIDTH: floor(a/b).
- `remainder`  out  WIDTH: a mod b.
- `div_by_zero`  out  1: the last completed operation had b == 0.

## Operation
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1).
- Internal registers:
  - `dcopy`, `bcopy`: WIDTH bits each; hold the captured operands.
  - `rem`: partial remainder, WIDTH+1 bits.
  - `qsh`: quotient/dividend shift register, WIDTH bits.
  - `cnt`: iteration counter, $clog2(WIDTH+1) bits.
- Start, on any edge with `enable`=1, in any state:
  - Capture `a` and `b`.
  - Set `rem`=0, `qsh`=a, `cnt`=0.
  - Set `valid`=0 and `busy`=1, then enter RUN.
- RUN iteration, once per edge while `enable`=0:
  - trial = {rem[WIDTH-1:0], qsh[WIDTH-1]} - {1'b0, bcopy}, computed in WIDTH+1 bits.
  - No borrow (trial MSB = 0): rem ← trial; qsh ← {qsh[WIDTH-2:0], 1}.
  - Borrow: rem ← {rem[WIDTH-1:0], qsh[WIDTH-1]}; qsh ← {qsh[WIDTH-2:0], 0}.
  - cnt ← cnt+1.
- Completion, on the edge that performs iteration WIDTH:
  - `quotient` ← the final qsh value.
  - `remainder` ← the final rem[WIDTH-1:0].
  - `div_by_zero` ← (bcopy == 0).
  - `done`=1 and `valid`=1 for one cycle, `busy`=0, then return to IDLE.
- Divide by zero falls out of the algorithm with no special case: quotient = all ones, remainder = a.
- Results and `valid` hold until the next start. The outputs are not affected by input changes during RUN.
- `enable` while busy aborts the current operation silently (no `done`) and restarts it with the new operands.

## Timing
- Reset (`rst`=0): `busy`=0, `done`=0, `valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. Internal registers clear.
- Reset asserted mid-operation aborts the operation immediately and asynchronously. No `done` is produced. Operation resumes in IDLE after reset deasserts.
- Latency, with the start sampled on edge N:
  - `busy` is high from after edge N until edge N+WIDTH.
  - `done`/`valid` go high after edge N+WIDTH.
  - `done` goes low after edge N+WIDTH+1.
- Back-to-back operation: `enable` may be asserted in the same cycle `done` is high. That edge starts the new operation, and `valid` falls.
- A start in the same cycle as the completing iteration wins: no `done`, and a new operation begins.
- `done` is never high while `busy` is high.

## Configuration
- `DIVUINT_EARLY_DIV0_EN`:
  - Defined: if b == 0 is captured, the first RUN edge (N+1) completes immediately with `quotient` = all ones, `remainder` = a, `div_by_zero`=1 and `done`/`valid`=1. Latency is 1 cycle.
  - Undefined: divide by zero runs the full WIDTH iterations with the same final values. Latency is WIDTH cycles.
  - Nonzero divisors are identical in both builds.

## Test plan
- WIDTH=10, start with a=100, b=7 → after edge N+10: `quotient`=14, `remainder`=2, `done` for one cycle, `div_by_zero`=0, `busy` low.
- a=1023, b=1 → `quotient`=1023, `remainder`=0. Then a=5, b=9 → `quotient`=0, `remainder`=5.
- a=37, b=0 → `quotient`=1023, `remainder`=37, `div_by_zero`=1. `done` after edge N+10 without the macro, and after edge N+1 with `DIVUINT_EARLY_DIV0_EN`.
- Start a=100, b=7; at edge N+4 re-assert `enable` with a=50, b=6 → no `done` at N+10; `done` after edge N+14 with `quotient`=8, `remainder`=2.
- Start an operation; pull `rst` low at N+5 between edges → all outputs are 0 immediately. After release, no `done` occurs until a new start.
- Assert `enable` (a=9, b=3) in the cycle `done` is high → `valid` falls next cycle; after 10 more edges `quotient`=3, `remainder`=0.

Source files
------------

// File: rtl/divuint_if.sv
// divuint_if: start/operand and result/status signals of the unsigned divider
interface divuint_if #(parameter int WIDTH = 10);
    logic             enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output enable, a, b,
        input  busy, done, valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  enable, a, b,
        output busy, done, valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divuint.sv
// divuint: restoring shift-subtract unsigned divider, one quotient bit per clock; DIVUINT_EARLY_DIV0_EN finishes b==0 in one cycle
module divuint #(parameter int WIDTH = 10) (
    input logic      clk,
    input logic      rst,
    divuint_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] bcopy;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qsh;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] qsh_nx;
    // one restoring step; the partial remainder always stays below the divisor so WIDTH bits hold it
    always_comb begin
        shifted = {rem, qsh[WIDTH-1]};
        trial   = shifted - {1'b0, bcopy};
        rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        qsh_nx  = {qsh[WIDTH-2:0], ~trial[WIDTH]};
    end
    // control FSM with registered results; a start always wins over work in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bcopy           <= '0;
            rem             <= '0;
            qsh             <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.valid       <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.enable) begin
                bcopy     <= bus.b;
                rem       <= '0;
                qsh       <= bus.a;
                cnt       <= '0;
                bus.valid <= 1'b0;
                bus.busy  <= 1'b1;
                state     <= RUN;
            end else if (state == RUN) begin
`ifdef DIVUINT_EARLY_DIV0_EN
                if (bcopy == '0) begin
                    bus.quotient    <= '1;
                    bus.remainder   <= qsh;
                    bus.div_by_zero <= 1'b1;
                    bus.done        <= 1'b1;
                    bus.valid       <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end else
`endif
                begin
                    rem <= rem_nx;
                    qsh <= qsh_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.quotient    <= qsh_nx;
                        bus.remainder   <= rem_nx;
                        bus.div_by_zero <= (bcopy == '0);
                        bus.done        <= 1'b1;
                        bus.valid       <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_divuint.sv
// tb_divuint: randomized scoreboard bench for divuint against an arithmetic reference
module tb_divuint;
    localparam int W = 10;
`ifdef DIVUINT_EARLY_DIV0_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef struct {
        int q;
        int r;
        bit dz;
        int done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;
    exp_t sb[$];

    divuint_if #(.WIDTH(W)) bus ();
    divuint #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // reference: plain integer division, b==0 yields all ones and the dividend
    task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bus.enable = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        sb.delete();
        e.q = (b == 0) ? (1 << W) - 1 : int'(a) / int'(b);
        e.r = (b == 0) ? int'(a) : int'(a) % int'(b);
        e.dz = (b == 0);
        e.done_at = cyc + ((EARLY && b == 0) ? 1 : W);
        sb.push_back(e);
        bus.enable = 1'b0;
    endtask

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start_now(a, b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // monitor: pop and compare whenever the DUT signals done
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_done at edge %0d: got done=1, expected 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_edge", cyc, e.done_at);
                    check("quotient", 32'(bus.quotient), e.q);
                    check("remainder", 32'(bus.remainder), e.r);
                    check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                    check("valid_at_done", 32'(bus.valid), 1);
                    check("busy_at_done", 32'(bus.busy), 0);
                end
            end else if (sb.size() != 0) begin
                if (cyc >= sb[0].done_at) begin
                    vectors++;
                    errs++;
                    $display("FAIL missing_done at edge %0d: got done=0, expected 1 at edge %0d", cyc, sb[0].done_at);
                    void'(sb.pop_front());
                end else begin
                    check("busy_in_run", 32'(bus.busy), 1);
                    check("valid_in_run", 32'(bus.valid), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        int gap;
        bus.enable = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_quotient", 32'(bus.quotient), 0);
        check("rst_remainder", 32'(bus.remainder), 0);
        check("rst_div_by_zero", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        go(100, 7);
        wait_idle();
        go(1023, 1);
        wait_idle();
        go(5, 9);
        wait_idle();
        go(37, 0);
        wait_idle();
        go(100, 7);
        repeat (3) @(negedge clk);
        go(50, 6);
        wait_idle();
        go(200, 3);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb.delete();
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_valid", 32'(bus.valid), 0);
        check("arst_quotient", 32'(bus.quotient), 0);
        check("arst_remainder", 32'(bus.remainder), 0);
        check("arst_div_by_zero", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("idle_after_rst", 32'(bus.busy), 0);
        go(17, 4);
        for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
        check("b2b_done_seen", 32'(bus.done), 1);
        start_now(9, 3);
        @(negedge clk);
        check("b2b_valid_fall", 32'(bus.valid), 0);
        wait_idle();
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom);
            go(ra, rb);
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
        end
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
